line_sequencer: RTL and testbench

Parametrised line-drawing sequencer that sits between control logic and `line_drawer` in the VGA datapath. It clears the screen column by column, then draws a programmable table of line segments with a start/done handshake. It holds the picture for a dwell period, then either stops or loops. Looping uses either a full clear or an erase-only redraw in background colour. It replaces hard-coded per-state coordinate assignment and the free-running slow-clock state stepping.

---
 rtl/line_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_line_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sequencer.sv
// line_sequencer: drives line_drawer through a full-screen clear (one vertical
// line per column), then a programmable table of line segments, holds the
// picture for a dwell period and either stops or loops (full clear or
// erase-only redraw in background colour).
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start, stop           begin sequence (IDLE only) / sticky halt request
//   loop_en, erase_mode   repeat forever / loop refresh by erase instead of clear
//   seg_we/addr/wdata     segment table write port, wdata = {en, x0, y0, x1, y1}
//   ld_done               one-cycle completion pulse from line_drawer
//   ld_start              one-cycle line request to line_drawer
//   x0, y0, x1, y1, color registered line endpoints and colour
//   busy, frame_done      not idle / end-of-dwell pulse
//   pass_count            completed passes (wraps)
module line_sequencer #(
    parameter int unsigned XW        = 11,
    parameter int unsigned YW        = 11,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned DWELL     = 37_500_000,
    localparam int unsigned AW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int unsigned SW = 1 + 2 * XW + 2 * YW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          erase_mode,
    input  logic          seg_we,
    input  logic [AW-1:0] seg_addr,
    input  logic [SW-1:0] seg_wdata,
    input  logic          ld_done,
    output logic          ld_start,
    output logic [XW-1:0] x0,
    output logic [YW-1:0] y0,
    output logic [XW-1:0] x1,
    output logic [YW-1:0] y1,
    output logic          color,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    pass_count
);

    localparam int unsigned DCW = $clog2(DWELL + 1);
    localparam logic [XW-1:0]  C_LAST   = XW'(SCREEN_W - 1);
    localparam logic [AW-1:0]  I_LAST   = AW'(NUM_LINES - 1);
    localparam logic [DCW-1:0] DW_LAST  = DCW'(DWELL - 1);
    localparam logic [DCW-1:0] DW_PEN   = DCW'((DWELL > 1) ? DWELL - 2 : 0);
    localparam logic           DW_ONE   = (DWELL == 1);
    localparam logic [AW:0]    ADDR_LIM = (AW + 1)'(NUM_LINES);

    typedef struct packed {
        logic          en;
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
    } seg_t;

    typedef struct packed {
        logic [XW-1:0] x0;
        logic [YW-1:0] y0;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic          color;
    } line_t;

    typedef enum logic [2:0] {
        IDLE, CLR_ISSUE, CLR_WAIT, ERS_ISSUE, ERS_WAIT, DRW_ISSUE, DRW_WAIT, DWELL_ST
    } state_t;

    state_t         state;
    seg_t           seg_tab [NUM_LINES];
    line_t          line_q;
    logic [XW-1:0]  c;
    logic [AW-1:0]  idx;
    logic [DCW-1:0] dwell_cnt;
    logic           stop_q;

    logic           last_c;
    logic           drawing_c;
    logic           adv_c;
    logic           stop_eff_c;
    logic           to_idle_c;
    logic [AW-1:0]  adv_idx_c;
    seg_t           load_ent_c;

    function automatic line_t clr_line(input logic [XW-1:0] col);
        line_t l;
        l.x0    = col;
        l.x1    = col;
        l.y0    = '0;
        l.y1    = YW'(SCREEN_H - 1);
        l.color = 1'b0;
        return l;
    endfunction

    function automatic line_t mk_line(input seg_t e, input logic col);
        line_t l;
        l.x0    = e.x0;
        l.y0    = e.y0;
        l.x1    = e.x1;
        l.y1    = e.y1;
        l.color = col;
        return l;
    endfunction

    assign x0    = line_q.x0;
    assign y0    = line_q.y0;
    assign x1    = line_q.x1;
    assign y1    = line_q.y1;
    assign color = line_q.color;

    // Segment table; entries read at the edge that issues them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_LINES; k++) seg_tab[k] <= '0;
        end else if (seg_we && ({1'b0, seg_addr} < ADDR_LIM)) begin
            seg_tab[seg_addr] <= seg_t'(seg_wdata);
        end
    end

    // Table walk helpers. An ISSUE with ld_start low is a disabled entry.
    always_comb begin
        last_c     = (idx == I_LAST);
        drawing_c  = (state == DRW_ISSUE) || (state == DRW_WAIT);
        adv_idx_c  = last_c ? '0 : idx + AW'(1);
        load_ent_c = ((state == DWELL_ST) || (state == CLR_WAIT)) ? seg_tab[0] : seg_tab[adv_idx_c];
        stop_eff_c = stop_q || stop;
        adv_c      = (((state == DRW_ISSUE) || (state == ERS_ISSUE)) && !ld_start) ||
                     (((state == DRW_WAIT) || (state == ERS_WAIT)) && ld_done);
        to_idle_c  = stop_eff_c &&
                     (((state == CLR_WAIT) && ld_done) || adv_c || (state == DWELL_ST));
    end

    // Sequencer FSM; outputs are loaded on the edge entering each ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            c          <= '0;
            idx        <= '0;
            dwell_cnt  <= '0;
            stop_q     <= 1'b0;
            ld_start   <= 1'b0;
            line_q     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pass_count <= '0;
        end else if (to_idle_c) begin
            state      <= IDLE;
            busy       <= 1'b0;
            ld_start   <= 1'b0;
            frame_done <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            stop_q     <= (state != IDLE) && stop_eff_c;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state    <= CLR_ISSUE;
                        busy     <= 1'b1;
                        c        <= '0;
                        ld_start <= 1'b1;
                        line_q   <= clr_line('0);
                    end
                end
                CLR_ISSUE: begin
                    ld_start <= 1'b0;
                    state    <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    if (ld_done) begin
                        if (c == C_LAST) begin
                            state    <= DRW_ISSUE;
                            idx      <= '0;
                            ld_start <= load_ent_c.en;
                            if (load_ent_c.en) line_q <= mk_line(load_ent_c, 1'b1);
                        end else begin
                            state    <= CLR_ISSUE;
                            c        <= c + XW'(1);
                            ld_start <= 1'b1;
                            line_q   <= clr_line(c + XW'(1));
                        end
                    end
                end
                DRW_ISSUE, ERS_ISSUE: begin
                    if (ld_start) begin
                        ld_start <= 1'b0;
                        state    <= drawing_c ? DRW_WAIT : ERS_WAIT;
                    end
                end
                DWELL_ST: begin
                    if (dwell_cnt == DW_LAST) begin
                        pass_count <= pass_count + 8'd1;
                        dwell_cnt  <= '0;
                        if (!loop_en) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            stop_q <= 1'b0;
                        end else if (!erase_mode) begin
                            state    <= CLR_ISSUE;
                            c        <= '0;
                            ld_start <= 1'b1;
                            line_q   <= clr_line('0);
                        end else begin
                            state    <= ERS_ISSUE;
                            idx      <= '0;
                            ld_start <= load_ent_c.en;
                            if (load_ent_c.en) line_q <= mk_line(load_ent_c, 1'b0);
                        end
                    end else begin
                        dwell_cnt  <= dwell_cnt + DCW'(1);
                        frame_done <= (dwell_cnt == DW_PEN);
                    end
                end
                default: ;
            endcase

            // Step to the next table entry; erase pass rolls into the draw pass.
            if (adv_c) begin
                if (last_c && drawing_c) begin
                    state      <= DWELL_ST;
                    dwell_cnt  <= '0;
                    frame_done <= DW_ONE;
                end else begin
                    idx      <= adv_idx_c;
                    state    <= (drawing_c || last_c) ? DRW_ISSUE : ERS_ISSUE;
                    ld_start <= load_ent_c.en;
                    if (load_ent_c.en) line_q <= mk_line(load_ent_c, drawing_c || last_c);
                end
            end
        end
    end

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: 4x3 screen, 2-entry table, 5-cycle dwell. A drawer
// model answers each ld_start with ld_done three cycles later; a monitor pops
// expected line requests and pass counts from a scoreboard.
module tb_line_sequencer;

    localparam int unsigned XW = 4;
    localparam int unsigned YW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          erase_mode = 1'b0;
    logic          seg_we = 1'b0;
    logic [0:0]    seg_addr = '0;
    logic [16:0]   seg_wdata = '0;
    logic          ld_done;
    logic          ld_start;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic          color;
    logic          busy;
    logic          frame_done;
    logic [7:0]    pass_count;

    int passed = 0;
    int total = 0;
    int exp_pass = 0;
    logic [31:0] req_q[$];

    line_sequencer #(
        .XW(XW), .YW(YW), .SCREEN_W(4), .SCREEN_H(3), .NUM_LINES(2), .DWELL(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .loop_en(loop_en), .erase_mode(erase_mode), .seg_we(seg_we),
        .seg_addr(seg_addr), .seg_wdata(seg_wdata), .ld_done(ld_done),
        .ld_start(ld_start), .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .busy(busy), .frame_done(frame_done), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] req(input int ax0, input int ay0, input int ax1,
                                        input int ay1, input logic col);
        return {15'd0, col, 4'(ax0), 4'(ay0), 4'(ax1), 4'(ay1)};
    endfunction

    // Drawer model: ld_done sampled four edges after the edge that raised ld_start.
    initial begin
        ld_done = 1'b0;
        forever begin
            @(negedge clk);
            ld_done = 1'b0;
            if (ld_start && reset_n) begin
                repeat (3) @(negedge clk);
                ld_done = 1'b1;
            end
        end
    end

    // Monitor: every request and every frame_done is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && ld_start) begin
                if (req_q.size() == 0) chk("unexpected_req", {15'd0, color, x0, y0, x1, y1}, 32'hFFFF_FFFF);
                else chk("line_req", {15'd0, color, x0, y0, x1, y1}, req_q.pop_front());
            end
            if (reset_n && frame_done) begin
                chk("frame_pass_count", 32'(pass_count), 32'(exp_pass));
                exp_pass = (exp_pass + 1) % 256;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    task automatic wr(input int a, input logic en, input int ax0, input int ay0,
                      input int ax1, input int ay1);
        @(negedge clk);
        seg_we    = 1'b1;
        seg_addr  = 1'(a);
        seg_wdata = {en, 4'(ax0), 4'(ay0), 4'(ax1), 4'(ay1)};
        @(negedge clk);
        seg_we = 1'b0;
    endtask

    task automatic push_clears(input int n);
        for (int i = 0; i < n; i++) req_q.push_back(req(i, 0, i, 2, 1'b0));
    endtask

    // Returns at the negedge following the edge that samples start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_done && n < 400);
    endtask

    task automatic wait_draw(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(ld_start && color) && n < 400);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 50);
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic push_pair(input logic col);
        req_q.push_back(req(0, 0, 3, 2, col));
        req_q.push_back(req(3, 0, 0, 2, col));
    endtask

    initial begin
        int n;

        // Reset held: inputs toggle, writes attempted, outputs stay zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = i[0]; stop = i[1]; loop_en = ~i[0]; erase_mode = i[2];
            seg_we = 1'b1; seg_addr = i[0]; seg_wdata = 17'($urandom);
            #1;
            chk("reset_outputs", {4'd0, ld_start, x0, x1, y0, y1, color, busy, frame_done, pass_count}, 32'd0);
        end
        @(negedge clk);
        start = 0; stop = 0; loop_en = 0; erase_mode = 0; seg_we = 0; seg_wdata = '0;
        reset_n = 1'b1;

        // Empty table: four clears only, dwell after two skipped entries.
        push_clears(4);
        chk("busy_before_start", 32'(busy), 32'd0);
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_frame(n);
        chk("empty_frame_latency", 32'(n), 32'd22);
        wait_idle();
        chk("empty_pass_count", 32'(pass_count), 32'd1);

        // Single pass with two enabled segments.
        wr(0, 1'b1, 0, 0, 3, 2);
        wr(1, 1'b1, 3, 0, 0, 2);
        push_clears(4);
        push_pair(1'b1);
        pulse_start();
        wait_frame(n);
        chk("single_frame_latency", 32'(n), 32'd28);
        wait_idle();
        chk("single_pass_count", 32'(pass_count), 32'd2);

        // Skip: disabled entry 0 costs one cycle, entry 1 issued right after.
        wr(0, 1'b0, 5, 5, 5, 5);
        push_clears(4);
        req_q.push_back(req(3, 0, 0, 2, 1'b1));
        pulse_start();
        wait_draw(n);
        chk("skip_draw_latency", 32'(n), 32'd17);
        wait_frame(n);
        chk("skip_frame_latency", 32'(n), 32'd8);
        wait_idle();
        chk("skip_pass_count", 32'(pass_count), 32'd3);

        // Loop with erase refresh: no clears after the first pass.
        wr(0, 1'b1, 0, 0, 3, 2);
        loop_en = 1'b1; erase_mode = 1'b1;
        push_clears(4);
        push_pair(1'b1);
        push_pair(1'b0); push_pair(1'b1);
        push_pair(1'b0); push_pair(1'b1);
        pulse_start();
        wait_frame(n);
        chk("loop_frame1_latency", 32'(n), 32'd28);
        wait_frame(n);
        chk("loop_frame2_latency", 32'(n), 32'd21);
        @(negedge clk);
        loop_en = 1'b0;
        wait_frame(n);
        chk("loop_frame3_seen", 32'(frame_done), 32'd1);
        wait_idle();
        chk("loop_pass_count", 32'(pass_count), 32'd6);
        erase_mode = 1'b0;

        // Stop during the column-1 clear wait.
        push_clears(2);
        pulse_start();
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        chk("stop_busy_before_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("stop_busy_after_done", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        chk("stop_no_more_reqs", 32'(req_q.size()), 32'd0);
        chk("stop_pass_count", 32'(pass_count), 32'd6);

        // start and stop together in IDLE.
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start_stop_busy_later", 32'(busy), 32'd0);

        // Asynchronous reset while a segment is being drawn.
        push_clears(4);
        push_pair(1'b1);
        pulse_start();
        wait_draw(n);
        chk("rst_draw_reached", 32'(n), 32'd16);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {4'd0, ld_start, x0, x1, y0, y1, color, busy, frame_done, pass_count}, 32'd0);
        req_q.delete();
        exp_pass = 0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;

        // Table cleared by reset: clear-only pass.
        push_clears(4);
        pulse_start();
        wait_frame(n);
        chk("post_reset_frame_latency", 32'(n), 32'd22);
        wait_idle();
        chk("post_reset_pass_count", 32'(pass_count), 32'd1);
        chk("scoreboard_drained", 32'(req_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
